// File: rtl/fifo_serializer_pkg.sv
// Shared types and sizing helpers for the FIFO word serializer.
// Imported by the serializer top.
package fifo_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SEND      = 2'd2
    } state_e;

    function automatic int beats_of(input int ww, input int bw);
        return ww / bw;
    endfunction

    function automatic int cnt_width(input int ww, input int bw);
        return ((ww / bw) > 1) ? $clog2(ww / bw) : 1;
    endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops words from a FIFO read port and emits them as narrower
// valid/ready beats; supports FWFT and registered-read FIFOs.
module fifo_word_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int BEAT_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic [WORD_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_read_o,
    output logic [BEAT_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i,
    output logic                  busy_o
);

    localparam int BEATS = beats_of(WORD_WIDTH, BEAT_WIDTH);
    localparam int CW    = cnt_width(WORD_WIDTH, BEAT_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    if (((WORD_WIDTH % BEAT_WIDTH) != 0) || (BEATS < 2)) begin : g_bad_cfg
        $error("fifo_word_serializer: bad WORD_WIDTH/BEAT_WIDTH");
    end

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  xfer;
    logic                  is_last;

    assign is_last = (cnt_q == LAST_CNT);
    assign valid_o = (state_q == SEND);
    assign last_o  = valid_o & is_last;
    assign busy_o  = (state_q != IDLE);
    assign xfer    = clk_en_i & valid_o & ready_i;

    // Read-out end is the low beat for LSB-first, the high beat otherwise.
    assign data_o = (MSB_FIRST != 0) ? shreg_q[WORD_WIDTH-1 -: BEAT_WIDTH]
                                     : shreg_q[BEAT_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        fifo_read_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clk_en_i && !fifo_empty_i) begin
                    fifo_read_o = 1'b1;
                    if (FWFT != 0) begin
                        shreg_d = fifo_rd_data_i;
                        cnt_d   = '0;
                        state_d = SEND;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (clk_en_i) begin
                    shreg_d = fifo_rd_data_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!is_last) begin
                        shreg_d = (MSB_FIRST != 0) ? (shreg_q << BEAT_WIDTH)
                                                   : (shreg_q >> BEAT_WIDTH);
                        cnt_d   = cnt_q + 1'b1;
                    end else if (!fifo_empty_i) begin
                        // Back-to-back: pop the next word on the last beat.
                        fifo_read_o = 1'b1;
                        if (FWFT != 0) begin
                            shreg_d = fifo_rd_data_i;
                            cnt_d   = '0;
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: three serializer configurations fed by
// behavioural FIFO models, beats checked by a negedge monitor.
module tb_fifo_word_serializer;

    logic        clk;
    logic        rst_n;
    logic        en    [3];
    logic        ready [3];
    logic        rd    [3];
    logic        empty [3];
    logic [31:0] rdd   [3];
    logic [31:0] rdreg [3];
    logic [7:0]  data  [3];
    logic        valid [3];
    logic        last  [3];
    logic        busy  [3];

    logic [31:0] mem [3][16];
    int          wp  [3];
    int          rp  [3];

    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    logic [8:0] exp2[$];

    int total = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: standard LSB-first, dut1: FWFT LSB-first, dut2: standard MSB-first
    fifo_word_serializer #(.WORD_WIDTH(32), .BEAT_WIDTH(8), .FWFT(0), .MSB_FIRST(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(en[0]),
        .fifo_rd_data_i(rdd[0]), .fifo_empty_i(empty[0]), .fifo_read_o(rd[0]),
        .data_o(data[0]), .valid_o(valid[0]), .last_o(last[0]),
        .ready_i(ready[0]), .busy_o(busy[0])
    );
    fifo_word_serializer #(.WORD_WIDTH(32), .BEAT_WIDTH(8), .FWFT(1), .MSB_FIRST(0)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(en[1]),
        .fifo_rd_data_i(rdd[1]), .fifo_empty_i(empty[1]), .fifo_read_o(rd[1]),
        .data_o(data[1]), .valid_o(valid[1]), .last_o(last[1]),
        .ready_i(ready[1]), .busy_o(busy[1])
    );
    fifo_word_serializer #(.WORD_WIDTH(32), .BEAT_WIDTH(8), .FWFT(0), .MSB_FIRST(1)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(en[2]),
        .fifo_rd_data_i(rdd[2]), .fifo_empty_i(empty[2]), .fifo_read_o(rd[2]),
        .data_o(data[2]), .valid_o(valid[2]), .last_o(last[2]),
        .ready_i(ready[2]), .busy_o(busy[2])
    );

    assign empty[0] = (wp[0] == rp[0]);
    assign empty[1] = (wp[1] == rp[1]);
    assign empty[2] = (wp[2] == rp[2]);
    assign rdd[0]   = rdreg[0];
    assign rdd[1]   = mem[1][rp[1] & 15];
    assign rdd[2]   = rdreg[2];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && rd[i]) begin
                rp[i]    <= rp[i] + 1;
                rdreg[i] <= mem[i][rp[i] & 15];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Monitor: compare every accepted beat against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (rd[i]) chk($sformatf("dut%0d_pop_nonempty", i), 32'(empty[i]), 32'd0);
            end
            if (en[0] && valid[0] && ready[0]) begin
                if (exp0.size() == 0) chk("dut0_unexpected_beat", 32'(data[0]), 32'hFFFF_FFFF);
                else chk("dut0_beat", {23'd0, last[0], data[0]}, {23'd0, exp0.pop_front()});
            end
            if (en[1] && valid[1] && ready[1]) begin
                if (exp1.size() == 0) chk("dut1_unexpected_beat", 32'(data[1]), 32'hFFFF_FFFF);
                else chk("dut1_beat", {23'd0, last[1], data[1]}, {23'd0, exp1.pop_front()});
            end
            if (en[2] && valid[2] && ready[2]) begin
                if (exp2.size() == 0) chk("dut2_unexpected_beat", 32'(data[2]), 32'hFFFF_FFFF);
                else chk("dut2_beat", {23'd0, last[2], data[2]}, {23'd0, exp2.pop_front()});
            end
        end
    end

    task automatic push(input int i, input logic [31:0] w);
        logic [7:0] b;
        mem[i][wp[i] & 15] = w;
        wp[i] = wp[i] + 1;
        for (int k = 0; k < 4; k++) begin
            b = (i == 2) ? w[8*(3-k) +: 8] : w[8*k +: 8];
            case (i)
                0: exp0.push_back({(k == 3), b});
                1: exp1.push_back({(k == 3), b});
                default: exp2.push_back({(k == 3), b});
            endcase
        end
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy[i] && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("dut%0d_idle_timeout", i), 32'(busy[i]), 32'd0);
    endtask

    task automatic wait_beat0(input logic [7:0] v);
        int n = 0;
        while (!(valid[0] && data[0] == v) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dut0_wait_beat_timeout", 32'(n < 30), 32'd1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b1; ready[i] = 1'b1; wp[i] = 0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), 32'(valid[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst_read%0d", i), 32'(rd[i]), 32'd0);
        end
        chk("rst_last0", 32'(last[0]), 32'd0);
        chk("rst_data0", 32'(data[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Standard mode: single pop, WAIT_DATA bubble, then AA..DD
        push(0, 32'hDDCCBBAA);
        @(negedge clk);
        chk("t1_pop", 32'(rd[0]), 32'd1);
        @(negedge clk);
        chk("t1_pop_single", 32'(rd[0]), 32'd0);
        chk("t1_wait_valid", 32'(valid[0]), 32'd0);
        chk("t1_wait_busy", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("t1_first_valid", 32'(valid[0]), 32'd1);
        chk("t1_first_data", 32'(data[0]), 32'hAA);
        @(posedge clk); #1;
        wait_idle(0);
        chk("t1_valid_after", 32'(valid[0]), 32'd0);

        // FWFT: two words, eight beats with no gap
        push(1, 32'h04030201);
        push(1, 32'h08070605);
        @(negedge clk);
        chk("t2_pop0", 32'(rd[1]), 32'd1);
        chk("t2_valid0", 32'(valid[1]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("t2_valid_b%0d", k), 32'(valid[1]), 32'd1);
            chk($sformatf("t2_pop_b%0d", k), 32'(rd[1]), 32'(k == 4));
        end
        @(negedge clk);
        chk("t2_valid_end", 32'(valid[1]), 32'd0);

        // Backpressure at BB
        @(posedge clk); #1;
        push(0, 32'hDDCCBBAA);
        wait_beat0(8'hBB);
        ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_valid_hold", 32'(valid[0]), 32'd1);
            chk("t3_data_hold", 32'(data[0]), 32'hBB);
            chk("t3_last_hold", 32'(last[0]), 32'd0);
            @(posedge clk); #1;
        end
        ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("t3_next_cc", 32'(data[0]), 32'hCC);
        wait_idle(0);

        // MSB-first ordering
        push(2, 32'h11223344);
        wait_idle(2);

        // Clock enable low at BB
        push(0, 32'hDDCCBBAA);
        wait_beat0(8'hBB);
        en[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t5_no_pop", 32'(rd[0]), 32'd0);
            chk("t5_valid_hold", 32'(valid[0]), 32'd1);
            chk("t5_data_hold", 32'(data[0]), 32'hBB);
            @(posedge clk); #1;
        end
        en[0] = 1'b1;
        @(posedge clk); #1;
        chk("t5_resume_cc", 32'(data[0]), 32'hCC);
        wait_idle(0);

        // Asynchronous reset while CC is presented
        push(0, 32'hDDCCBBAA);
        wait_beat0(8'hCC);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid_async", 32'(valid[0]), 32'd0);
        chk("t6_busy_async", 32'(busy[0]), 32'd0);
        chk("t6_read_async", 32'(rd[0]), 32'd0);
        exp0.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid[0]) seen++;
        end
        chk("t6_no_beats_after_reset", 32'(seen), 32'd0);

        chk("sb0_drained", 32'(exp0.size()), 32'd0);
        chk("sb1_drained", 32'(exp1.size()), 32'd0);
        chk("sb2_drained", 32'(exp2.size()), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
